// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker: drives every N-bit vector, samples dut_y, and scores it against EXP.
// Latency: a sweep takes 2^N*HOLD clocks from the edge that accepts start; all outputs are registered.
// No backpressure: start is only accepted in IDLE/DONE; a start pulse during a sweep is dropped.
module truth_table_sweeper #(
    parameter int                N    = 3,
    parameter int                HOLD = 1,
    parameter logic [(1<<N)-1:0] EXP  = 8'b1110_0010
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] dut_in,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_idx
);
    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N:0]    VEC_LAST  = {1'b0, {N{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state;
    logic [N:0]    vec;
    logic [N:0]    vec_nxt;
    logic [HW-1:0] hold;
    logic          sample;
    logic          mismatch;
    logic [N:0]    err_nxt;

    // The vector counter carries one extra bit so the last vector is seen before any wrap.
    assign vec_nxt  = vec + {{N{1'b0}}, 1'b1};
    assign sample   = (hold == HOLD_LAST);
    assign mismatch = (dut_y != EXP[vec[N-1:0]]);
    assign err_nxt  = err_cnt + {{N{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            vec           <= '0;
            hold          <= '0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_idx <= '0;
                        vec           <= '0;
                        hold          <= '0;
                        dut_in        <= '0;
                    end
                end
                S_RUN: begin
                    if (sample) begin
                        hold    <= '0;
                        vec     <= vec_nxt;
                        err_cnt <= err_nxt;
                        if (mismatch && (err_cnt == '0)) begin
                            first_err_idx <= vec[N-1:0];
                        end
                        // pass must include the compare made on this very edge, hence err_nxt.
                        if (vec == VEC_LAST) begin
                            state  <= S_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (err_nxt == '0);
                            dut_in <= '0;
                        end else begin
                            dut_in <= vec_nxt[N-1:0];
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, self-checking exhaustive stimulus engine for N-input combinational boolean blocks. On `start` it walks every input combination 0..2^N-1, holds each vector for HOLD clocks, samples the DUT output on the last hold cycle, and compares it against a golden truth table supplied as a parameter. It reports busy/done, an overall pass flag, a mismatch count and the index of the first failing vector. It replaces free-running per-input toggle stimulus with one synthesizable, clocked checker that can sit on the board next to the function under test.

## Interface
- `N`, default 3: number of DUT inputs (1..8).
- `HOLD`, default 1: clocks each vector is held (>=1).
- `EXP`, default 8'b1110_0010: golden truth table, width 2^N. Bit v is the expected `dut_y` for input vector v.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin sweep. Accepted only in IDLE or DONE.
- `dut_in`  out  N: vector driven to the DUT. Bit N-1 is the slowest-toggling input, bit 0 the fastest.
- `dut_y`  in  1: DUT output, combinational from `dut_in`.
- `busy`  out  1: sweep in progress.
- `done`  out  1: sweep complete. Held until the next accepted start or reset.
- `pass`  out  1: valid while `done`=1. High iff `err_cnt`==0.
- `err_cnt`  out  N+1: number of mismatching vectors (0..2^N).
- `first_err_idx`  out  N: vector index of the first mismatch. Valid iff `err_cnt`!=0.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- Reset (async assert, any state) forces:
  - state=IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_idx`=0;
  - internal vector counter and hold counter to 0.
- IDLE/DONE with `start`=1 at an edge:
  - go to RUN; `busy`=1, `done`=0, `pass`=0;
  - clear `err_cnt` and `first_err_idx`; vector v=0, hold counter=0.
- RUN:
  - `dut_in`=v.
  - The hold counter counts 0..HOLD-1.
  - At the edge where hold==HOLD-1, compare `dut_y` with EXP[v]. On mismatch, increment `err_cnt`; if `err_cnt` was 0, load `first_err_idx`=v.
  - At that same edge, v increments and hold resets to 0.
- After vector 2^N-1 is sampled:
  - go to DONE; `busy`=0, `done`=1;
  - `pass`=(final `err_cnt`==0), including the last vector's compare;
  - `dut_in` returns to 0.
- `start` while in RUN is ignored: no restart, no counter change.
- The vector counter is N+1 bits internally so the terminal condition is detected without wrap. `dut_in` never shows a wrapped value.
- `err_cnt` saturation is unnecessary: the maximum is 2^N, which fits in N+1 bits.
- All outputs are registered. No combinational path exists from `dut_y` or `start` to any output.

## Timing
- Number edges from E0, the edge at which `start` is accepted.
- Vector v is driven after edge E(1+v·HOLD)... more precisely, `dut_in` changes right after E0+v·HOLD and holds through edge E0+(v+1)·HOLD.
- Vector v is sampled at edge E0+(v+1)·HOLD.
- `done`=1 and `busy`=0 are visible after edge E0+2^N·HOLD. Total sweep length is 2^N·HOLD clocks.
- `dut_y` must settle within HOLD clock periods minus setup. With HOLD=1 the DUT path must meet a single cycle.
- A reset asserted mid-RUN takes effect immediately (asynchronous). After deassertion the block waits in IDLE for a new `start`; no partial results are retained.
- `start` asserted at the same edge that would enter DONE is ignored, because state is still RUN. DONE is entered, and the next `start` is accepted in DONE.
- `start` held high continuously restarts a new sweep at the first edge in DONE. `done` is then high for exactly one cycle.

## Test plan
- **Correct DUT.** N=3, HOLD=2, EXP=8'b1110_0010, DUT modelled as the EXP lookup, one `start` pulse.
  - `dut_in` sequence 0..7, two clocks each.
  - `done` after 16 clocks; `pass`=1, `err_cnt`=0.
- **Single injected fault.** Same setup, DUT output inverted only at vector 5.
  - `err_cnt`=1, `first_err_idx`=5, `pass`=0.
- **Fully inverted DUT.** Same setup, DUT output is ~EXP lookup.
  - `err_cnt`=8, `first_err_idx`=0, `pass`=0.
- **Start ignored and mid-sweep reset.** Pulse `start` again at clock 6 of the sweep: sequence unaffected. Assert `rst_n`=0 at clock 9.
  - All outputs 0 at once.
  - After release plus `start`, a full clean sweep gives `pass`=1.
- **Wider, single-hold.** N=4, HOLD=1, EXP=16'hA55A, correct DUT.
  - `done` after exactly 16 clocks; `dut_in` increments every clock.
  - `pass`=1, `err_cnt`=0.
- **Back-to-back sweeps.** `start` held high continuously.
  - `done` pulses for one cycle; a second sweep begins with `err_cnt` cleared.
